hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline interlock controller for the 5-stage MIPS core; sequences the forwarding datapath.
//  Detects hazards that forwarding cannot cover: load-use, and branch/JR/JALR operands resolved in ID.
//  Inserts 1-2 ID/EX bubbles, freezes the pipe on I/D-cache stalls and flushes IF/ID on taken branches.
//  Drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB enables/flushes from one FSM.
// PARAMETERS
//  CNT_W    2   width of the remaining-bubble counter (max depth 2^CNT_W-1, >=2 required)
//  PERF_W   32  width of performance counters (HAZARD_PERF_EN only)
// PORTS
//  clk             in   1   core clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  IfId_Opcode     in   6   opcode of instruction in ID
//  IfId_Funct4b    in   4   funct[3:0] of instruction in ID
//  IfIdRs/IfIdRt   in   5   source regs of instruction in ID
//  IdEx_MemRead    in   1   EX-stage instruction is a load
//  IdEx_RegWrite   in   1   EX-stage instruction writes a register
//  IdExRd          in   5   EX-stage destination (post RegDst mux)
//  ExMem_MemRead   in   1   MEM-stage instruction is a load
//  ExMemRd         in   5   MEM-stage destination
//  Branch_taken    in   1   ID branch/jump resolved taken (valid only when no hazard)
//  ICache_stall    in   1   instruction fetch not ready
//  DCache_stall    in   1   data access not ready
//  PC_en, IfId_en  out  1   load enables
//  IfId_flush      out  1   zero IF/ID on taken branch
//  IdEx_flush      out  1   load bubble (all controls 0) into ID/EX
//  ExMem_en, MemWb_en out 1 load enables
//  state_o         out  2   FSM state (debug)
// BEHAVIOUR
//  Reset (async): state=RUN, cnt=0, ret=RUN; outputs while rst_n=0: all enables 0, flushes 0.
//  Hazard depth D (combinational, ID stage), rd!=0 required for every match, match = rd==Rs||rd==Rt:
//   - load-use: IdEx_MemRead && match(IdExRd) -> D=1
//   - branch-use (BEQ,BNE,R-type JR/JALR): IdEx_MemRead&&match(IdExRd) -> D=2;
//     else IdEx_RegWrite&&match(IdExRd) -> D=1; else ExMem_MemRead&&match(ExMemRd) -> D=1; else D=0.
//  States: RUN, BUBBLE, FREEZE.
//   RUN: D=0 -> all enables 1, IfId_flush=Branch_taken. D>0 -> PC_en=IfId_en=0, IdEx_flush=1,
//     IfId_flush=0; D=2 -> BUBBLE with cnt=1; D=1 -> stay RUN (re-evaluated next cycle).
//   BUBBLE: PC_en=IfId_en=0, IdEx_flush=1; cnt-- ; cnt==1 at entry -> RUN next cycle.
//   FREEZE: every enable 0, every flush 0; cnt and ret held; exit to ret when both stalls low.
//  Either cache stall high in any state -> outputs as FREEZE this cycle (combinational override),
//   ret<=current state if not already FREEZE, next state FREEZE. No bubble is lost or duplicated.
//  Branch_taken ignored whenever D>0, in BUBBLE or when frozen.
//  Simultaneous: stall beats hazard beats taken-branch. Reset mid-bubble aborts it (cnt=0).
//  Latency: zero-cycle combinational enables; state update at clk rising edge.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_bubbles[PERF_W], perf_freeze[PERF_W], perf_flush[PERF_W],
//   each +1 per cycle with IdEx_flush / FREEZE outputs / IfId_flush; saturate at all-ones; reset 0.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  mips_pkg: opcodes BEQ/BNE/R_type, funct4b JR/JALR, state encoding RUN=0,BUBBLE=1,FREEZE=2.
//  Sub-module hazard_detect (combinational): IF/ID + EX/MEM fields -> D[1:0]; FSM stays top-level.
// TESTING
//  lw $5 in EX, add rs=$5 in ID -> one cycle PC_en=0,IdEx_flush=1, then normal flow.
//  lw $5 in EX, beq $5,$6 in ID -> exactly 2 bubble cycles (RUN->BUBBLE->RUN), beq then proceeds.
//  add $7 in EX, beq $7 in ID, Branch_taken=1 -> 1 bubble, then IfId_flush=1 for one cycle.
//  DCache_stall 3 cycles during BUBBLE -> 3 freeze cycles, then 1 remaining bubble, total bubbles 2.
//  Hazard on rd=$0 (lw $0) -> no bubble; rst_n low mid-BUBBLE -> state RUN, outputs 0 immediately.
//  HAZARD_PERF_EN: scenario 2 then 4 -> perf_bubbles=4, perf_freeze=3.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared opcode/funct constants and FSM state encoding for the pipeline interlock controller.
package hazard_stall_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [3:0] FN_JR    = 4'h8;
    localparam logic [3:0] FN_JALR  = 4'h9;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    // A destination only conflicts when it names a real register ($0 is never written).
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt);
        return (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side view of the interlock controller: ID/EX/MEM fields in, stage enables/flushes out.
interface hazard_stall_ctrl_if;

    logic [5:0] IfId_Opcode;
    logic [3:0] IfId_Funct4b;
    logic [4:0] IfIdRs;
    logic [4:0] IfIdRt;
    logic       IdEx_MemRead;
    logic       IdEx_RegWrite;
    logic [4:0] IdExRd;
    logic       ExMem_MemRead;
    logic [4:0] ExMemRd;
    logic       Branch_taken;
    logic       ICache_stall;
    logic       DCache_stall;
    logic       PC_en;
    logic       IfId_en;
    logic       IfId_flush;
    logic       IdEx_flush;
    logic       ExMem_en;
    logic       MemWb_en;
    logic [1:0] state_o;

    modport master (
        output IfId_Opcode, IfId_Funct4b, IfIdRs, IfIdRt, IdEx_MemRead, IdEx_RegWrite, IdExRd,
               ExMem_MemRead, ExMemRd, Branch_taken, ICache_stall, DCache_stall,
        input  PC_en, IfId_en, IfId_flush, IdEx_flush, ExMem_en, MemWb_en, state_o
    );

    modport slave (
        input  IfId_Opcode, IfId_Funct4b, IfIdRs, IfIdRt, IdEx_MemRead, IdEx_RegWrite, IdExRd,
               ExMem_MemRead, ExMemRd, Branch_taken, ICache_stall, DCache_stall,
        output PC_en, IfId_en, IfId_flush, IdEx_flush, ExMem_en, MemWb_en, state_o
    );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational hazard depth for the instruction in ID: 0 = none, 1 or 2 bubbles needed.
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [3:0] funct4b,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_rd,
    output logic [1:0] depth
);

    logic is_branch;
    logic hit_ex;
    logic hit_mem;

    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                       ((opcode == OP_RTYPE) && ((funct4b == FN_JR) || (funct4b == FN_JALR)));
    assign hit_ex    = reg_match(ex_rd, rs, rt);
    assign hit_mem   = reg_match(mem_rd, rs, rt);

    // Branches compare operands in ID, so they also wait on ALU results and MEM-stage loads.
    always_comb begin
        depth = 2'd0;
        if (is_branch) begin
            if (ex_mem_read && hit_ex)
                depth = 2'd2;
            else if (ex_reg_write && hit_ex)
                depth = 2'd1;
            else if (mem_mem_read && hit_mem)
                depth = 2'd1;
        end else if (ex_mem_read && hit_ex) begin
            depth = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock FSM: bubbles, cache-stall freeze and taken-branch flush for the 5-stage core.
// Optional build macro HAZARD_PERF_EN adds saturating bubble/freeze/flush performance counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_bubbles,
    output logic [PERF_W-1:0] perf_freeze,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    state_t           state, state_nxt;
    state_t           ret, ret_nxt;
    state_t           act;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       depth;
    logic             stall;
    logic             pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en;

    hazard_detect u_detect (
        .opcode       (bus.IfId_Opcode),
        .funct4b      (bus.IfId_Funct4b),
        .rs           (bus.IfIdRs),
        .rt           (bus.IfIdRt),
        .ex_mem_read  (bus.IdEx_MemRead),
        .ex_reg_write (bus.IdEx_RegWrite),
        .ex_rd        (bus.IdExRd),
        .mem_mem_read (bus.ExMem_MemRead),
        .mem_rd       (bus.ExMemRd),
        .depth        (depth)
    );

    assign stall = bus.ICache_stall || bus.DCache_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            ret   <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ret   <= ret_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Once the stalls drop, FREEZE behaves as the saved state in that same cycle, so the
    // number of frozen cycles equals the number of stalled cycles and no bubble is lost.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        state_nxt  = state;
        ret_nxt    = ret;
        cnt_nxt    = cnt;
        act        = (state == ST_FREEZE) ? ret : state;
        if (!rst_n) begin
            state_nxt = ST_RUN;
        end else if (stall) begin
            state_nxt = ST_FREEZE;
            ret_nxt   = act;
        end else begin
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            ret_nxt  = ST_RUN;
            case (act)
                ST_BUBBLE: begin
                    idex_flush = 1'b1;
                    cnt_nxt    = cnt - CNT_W'(1);
                    state_nxt  = (cnt == CNT_W'(1)) ? ST_RUN : ST_BUBBLE;
                end
                default: begin
                    if (depth == 2'd0) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = bus.Branch_taken;
                        state_nxt  = ST_RUN;
                    end else begin
                        idex_flush = 1'b1;
                        if (depth > 2'd1) begin
                            state_nxt = ST_BUBBLE;
                            cnt_nxt   = CNT_W'(depth - 2'd1);
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.PC_en      = pc_en;
    assign bus.IfId_en    = ifid_en;
    assign bus.IfId_flush = ifid_flush;
    assign bus.IdEx_flush = idex_flush;
    assign bus.ExMem_en   = exmem_en;
    assign bus.MemWb_en   = memwb_en;
    assign bus.state_o    = state;

`ifdef HAZARD_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != {PERF_W{1'b1}})) ? v + PERF_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubbles <= '0;
            perf_freeze  <= '0;
            perf_flush   <= '0;
        end else begin
            perf_bubbles <= sat_inc(perf_bubbles, idex_flush);
            perf_freeze  <= sat_inc(perf_freeze, stall);
            perf_flush   <= sat_inc(perf_flush, ifid_flush);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed pipeline scenarios then randomized traffic.
module tb_hazard_stall_ctrl;

    localparam logic [5:0] R_OP = 6'h00, BEQ_OP = 6'h04, BNE_OP = 6'h05, LW_OP = 6'h23, ADDI_OP = 6'h08;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] pb, pf, pl;
`endif

    hazard_stall_ctrl #(.CNT_W(2), .PERF_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef HAZARD_PERF_EN
        ,
        .perf_bubbles (pb),
        .perf_freeze  (pf),
        .perf_flush   (pl)
`endif
    );

    // {PC_en, IfId_en, IfId_flush, IdEx_flush, ExMem_en, MemWb_en, state_o[1:0]}
    typedef logic [7:0] exp_t;
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pend = 0;
    bit   stalled = 0;
    int   dut_bub = 0;
    int   dut_frz = 0;

    function automatic int depth_of(input logic [5:0] op, input logic [3:0] fn,
                                    input logic [4:0] rs, input logic [4:0] rt,
                                    input logic mr, input logic rw, input logic [4:0] rd,
                                    input logic mmr, input logic [4:0] mrd);
        bit br, hit_ex, hit_mem;
        br      = (op == BEQ_OP) || (op == BNE_OP) || (op == R_OP && (fn == 4'h8 || fn == 4'h9));
        hit_ex  = (rd != 0) && (rd == rs || rd == rt);
        hit_mem = (mrd != 0) && (mrd == rs || mrd == rt);
        if (!br) return (mr && hit_ex) ? 1 : 0;
        if (mr && hit_ex) return 2;
        if (rw && hit_ex) return 1;
        if (mmr && hit_mem) return 1;
        return 0;
    endfunction

    task automatic cycle(input logic r, input logic [5:0] op, input logic [3:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic rw, input logic [4:0] rd,
                         input logic mmr, input logic [4:0] mrd,
                         input logic bt, input logic ic, input logic dc);
        exp_t e;
        int   d;
        @(posedge clk);
        #1;
        rst_n              = r;
        bus.IfId_Opcode    = op;
        bus.IfId_Funct4b   = fn;
        bus.IfIdRs         = rs;
        bus.IfIdRt         = rt;
        bus.IdEx_MemRead   = mr;
        bus.IdEx_RegWrite  = rw;
        bus.IdExRd         = rd;
        bus.ExMem_MemRead  = mmr;
        bus.ExMemRd        = mrd;
        bus.Branch_taken   = bt;
        bus.ICache_stall   = ic;
        bus.DCache_stall   = dc;
        e = '0;
        if (!r) begin
            pend    = 0;
            stalled = 0;
        end else begin
            e[1:0] = stalled ? 2'd2 : (pend > 0 ? 2'd1 : 2'd0);
            if (ic || dc) begin
                stalled = 1;
            end else begin
                stalled = 0;
                if (pend > 0) begin
                    e[7:2] = 6'b000111;
                    pend   = pend - 1;
                end else begin
                    d = depth_of(op, fn, rs, rt, mr, rw, rd, mmr, mrd);
                    if (d > 0) begin
                        e[7:2] = 6'b000111;
                        pend   = d - 1;
                    end else begin
                        e[7:2] = {2'b11, bt, 3'b011};
                    end
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic nop(input logic bt);
        cycle(1'b1, ADDI_OP, 4'h0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, bt, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {bus.PC_en, bus.IfId_en, bus.IfId_flush, bus.IdEx_flush,
                 bus.ExMem_en, bus.MemWb_en, bus.state_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%b required=%b (pc,ifid_en,ifid_fl,idex_fl,exmem,memwb,state)",
                         $time, a, e);
            end
            if (bus.IdEx_flush === 1'b1) dut_bub++;
            if (rst_n && a[7:2] === 6'b000000) dut_frz++;
        end
    end

    initial begin
        int b0, f0;
        logic [5:0] op;
        logic [3:0] fn;
        // reset state
        cycle(1'b0, ADDI_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1'b0, ADDI_OP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        nop(1'b0);
        @(negedge clk);
        b0 = dut_bub;
        f0 = dut_frz;
`ifdef HAZARD_PERF_EN
        if (pb != 0 || pf != 0 || pl != 0) begin
            errors++;
            $display("FAIL perf_reset actual=%0d/%0d/%0d required=0/0/0", pb, pf, pl);
        end
        checks++;
`endif
        // lw $5 in EX, beq $5,$6 in ID: two bubbles, then beq proceeds and is taken
        cycle(1, BEQ_OP, 0, 5, 6, 1, 1, 5, 0, 0, 1, 0, 0);
        cycle(1, BEQ_OP, 0, 5, 6, 0, 0, 0, 1, 5, 1, 0, 0);
        cycle(1, BEQ_OP, 0, 5, 6, 0, 0, 0, 0, 0, 1, 0, 0);
        nop(1'b0);
        // D-cache stall for 3 cycles while in BUBBLE
        cycle(1, BNE_OP, 0, 5, 6, 1, 1, 5, 0, 0, 0, 0, 0);
        repeat (3) cycle(1, BNE_OP, 0, 5, 6, 0, 0, 0, 1, 5, 0, 0, 1);
        cycle(1, BNE_OP, 0, 5, 6, 0, 0, 0, 1, 5, 0, 0, 0);
        nop(1'b0);
        nop(1'b0);
        @(negedge clk);
        checks++;
        if (dut_bub - b0 != 4) begin
            errors++;
            $display("FAIL bubble_total actual=%0d required=4", dut_bub - b0);
        end
        checks++;
        if (dut_frz - f0 != 3) begin
            errors++;
            $display("FAIL freeze_total actual=%0d required=3", dut_frz - f0);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (pb != 4 || pf != 3 || pl != 1) begin
            errors++;
            $display("FAIL perf_counts actual=%0d/%0d/%0d required=4/3/1", pb, pf, pl);
        end
`endif
        // load-use on a non-branch
        cycle(1, R_OP, 4'h0, 5, 6, 1, 1, 5, 0, 0, 0, 0, 0);
        nop(1'b0);
        // add $7 in EX, beq $7 taken: one bubble then flush
        cycle(1, BEQ_OP, 0, 7, 1, 0, 1, 7, 0, 0, 1, 0, 0);
        cycle(1, BEQ_OP, 0, 7, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        nop(1'b0);
        // lw $0: no hazard
        cycle(1, R_OP, 4'h0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        // reset in the middle of a bubble
        cycle(1, R_OP, 4'h8, 3, 0, 1, 1, 3, 0, 0, 0, 0, 0);
        cycle(0, R_OP, 4'h8, 3, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        nop(1'b1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: op = R_OP;
                1: op = BEQ_OP;
                2: op = BNE_OP;
                default: op = LW_OP;
            endcase
            case ($urandom_range(0, 2))
                0: fn = 4'h8;
                1: fn = 4'h9;
                default: fn = 4'($urandom);
            endcase
            cycle(($urandom_range(0, 199) != 0), op, fn,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
